fsbl_rom_arbiter: RTL and testbench

//  Shares the single-port, read-only FSBL ROM between the instruction-fetch
//  and data memory ports of the core. Each port uses a req/gnt request

---
 rtl/fsbl_rom_arbiter.sv | 118 +++++++++++
 tb/tb_fsbl_rom_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsbl_rom_arbiter.sv
// Two-port (imem/dmem) arbiter in front of the single-port read-only FSBL ROM.
// Bad accesses (writes, misaligned, out of range) get an error response without touching the ROM.
module fsbl_rom_arbiter #(
    parameter int unsigned ROM_SIZE   = 256,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        imem_req,
    output logic        imem_gnt,
    input  logic [11:0] imem_addr,
    input  logic        imem_wen,
    input  logic [3:0]  imem_strb,
    input  logic [31:0] imem_wdata,
    output logic        imem_recv,
    input  logic        imem_ack,
    output logic [31:0] imem_rdata,
    output logic        imem_error,
    input  logic        dmem_req,
    output logic        dmem_gnt,
    input  logic [11:0] dmem_addr,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_recv,
    input  logic        dmem_ack,
    output logic [31:0] dmem_rdata,
    output logic        dmem_error,
    output logic        rom_cen,
    output logic [11:0] rom_addr,
    output logic [31:0] rom_wdata,
    output logic [3:0]  rom_wstrb,
    input  logic [31:0] rom_rdata
);

    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic {PORT_IMEM, PORT_DMEM} port_t;

    localparam logic [12:0] ROM_LIMIT = 13'(ROM_SIZE);

    state_t      state, state_nxt;
    port_t       owner, last_grant, sel;
    logic        err_q;
    logic        accept, bad, owner_ack, acc_wen;
    logic [11:0] acc_addr;
    logic        unused_inputs;

    assign unused_inputs = ^{imem_strb, imem_wdata, dmem_strb, dmem_wdata};
    assign rom_wdata     = '0;
    assign rom_wstrb     = '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= PORT_IMEM;
            last_grant <= PORT_DMEM;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= sel;
                last_grant <= sel;
                err_q      <= bad;
            end else if (state == RESP && owner_ack) begin
                err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        // On a tie, round-robin hands the grant to whichever port did not win last
        if (imem_req && dmem_req)
            sel = (FIXED_PRIO || last_grant == PORT_DMEM) ? PORT_IMEM : PORT_DMEM;
        else if (dmem_req)
            sel = PORT_DMEM;
        else
            sel = PORT_IMEM;

        accept    = (state == IDLE) && (imem_req || dmem_req);
        acc_addr  = (sel == PORT_DMEM) ? dmem_addr : imem_addr;
        acc_wen   = (sel == PORT_DMEM) ? dmem_wen : imem_wen;
        bad       = acc_wen || (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= ROM_LIMIT);
        owner_ack = (owner == PORT_DMEM) ? dmem_ack : imem_ack;

        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RESP;
            RESP:    if (owner_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_gnt   = accept && (sel == PORT_IMEM);
        dmem_gnt   = accept && (sel == PORT_DMEM);
        rom_cen    = accept && !bad;
        rom_addr   = rom_cen ? acc_addr : '0;
        imem_recv  = 1'b0;
        imem_error = 1'b0;
        imem_rdata = '0;
        dmem_recv  = 1'b0;
        dmem_error = 1'b0;
        dmem_rdata = '0;
        // rom_cen stays low in RESP, so rom_rdata is the word read at accept
        if (state == RESP) begin
            if (owner == PORT_IMEM) begin
                imem_recv  = 1'b1;
                imem_error = err_q;
                imem_rdata = err_q ? '0 : rom_rdata;
            end else begin
                dmem_recv  = 1'b1;
                dmem_error = err_q;
                dmem_rdata = err_q ? '0 : rom_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fsbl_rom_arbiter.sv
// Self-checking bench for fsbl_rom_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_fsbl_rom_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_req, i_wen, i_ack, d_req, d_wen, d_ack;
    logic [11:0] i_addr, d_addr;
    logic [3:0]  i_strb = 4'hF, d_strb = 4'h3;
    logic [31:0] i_wdata = 32'hDEADBEEF, d_wdata = 32'hCAFEF00D;

    logic        i_gnt0, i_recv0, i_err0, d_gnt0, d_recv0, d_err0, cen0;
    logic [31:0] i_rd0, d_rd0, rom_rd0, wd0;
    logic [11:0] ra0;
    logic [3:0]  ws0;
    logic        i_gnt1, i_recv1, i_err1, d_gnt1, d_recv1, d_err1, cen1;
    logic [31:0] i_rd1, d_rd1, rom_rd1, wd1;
    logic [11:0] ra1;
    logic [3:0]  ws1;

    int n_checks = 0;
    int n_fail   = 0;
    int cen_cnt0 = 0;

    always #5 clk = ~clk;

    fsbl_rom_arbiter #(.ROM_SIZE(256), .FIXED_PRIO(1'b0)) u0 (
        .clk(clk), .resetn(resetn),
        .imem_req(i_req), .imem_gnt(i_gnt0), .imem_addr(i_addr), .imem_wen(i_wen),
        .imem_strb(i_strb), .imem_wdata(i_wdata), .imem_recv(i_recv0), .imem_ack(i_ack),
        .imem_rdata(i_rd0), .imem_error(i_err0),
        .dmem_req(d_req), .dmem_gnt(d_gnt0), .dmem_addr(d_addr), .dmem_wen(d_wen),
        .dmem_strb(d_strb), .dmem_wdata(d_wdata), .dmem_recv(d_recv0), .dmem_ack(d_ack),
        .dmem_rdata(d_rd0), .dmem_error(d_err0),
        .rom_cen(cen0), .rom_addr(ra0), .rom_wdata(wd0), .rom_wstrb(ws0), .rom_rdata(rom_rd0)
    );

    fsbl_rom_arbiter #(.ROM_SIZE(256), .FIXED_PRIO(1'b1)) u1 (
        .clk(clk), .resetn(resetn),
        .imem_req(i_req), .imem_gnt(i_gnt1), .imem_addr(i_addr), .imem_wen(i_wen),
        .imem_strb(i_strb), .imem_wdata(i_wdata), .imem_recv(i_recv1), .imem_ack(i_ack),
        .imem_rdata(i_rd1), .imem_error(i_err1),
        .dmem_req(d_req), .dmem_gnt(d_gnt1), .dmem_addr(d_addr), .dmem_wen(d_wen),
        .dmem_strb(d_strb), .dmem_wdata(d_wdata), .dmem_recv(d_recv1), .dmem_ack(d_ack),
        .dmem_rdata(d_rd1), .dmem_error(d_err1),
        .rom_cen(cen1), .rom_addr(ra1), .rom_wdata(wd1), .rom_wstrb(ws1), .rom_rdata(rom_rd1)
    );

    function automatic logic [31:0] rom_word(input int unsigned idx);
        if (idx == 1) return 32'h11223344;
        return (idx * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    // ROM models: sample on the edge where cen is high, hold otherwise
    always @(posedge clk) begin
        if (cen0 === 1'b1) begin
            rom_rd0 <= rom_word(int'(ra0[11:2]));
            cen_cnt0 = cen_cnt0 + 1;
        end
        if (cen1 === 1'b1) rom_rd1 <= rom_word(int'(ra1[11:2]));
    end

    task automatic idle_inputs();
        i_req = 0; i_wen = 0; i_ack = 0; i_addr = '0;
        d_req = 0; d_wen = 0; d_ack = 0; d_addr = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Raise a request and wait for its grant on u0; returns cycles waited or -1
    task automatic issue(input bit dport, input logic [11:0] a, input bit w, output int waited);
        if (dport) begin d_req = 1; d_addr = a; d_wen = w; end
        else begin i_req = 1; i_addr = a; i_wen = w; end
        waited = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((dport ? d_gnt0 : i_gnt0) === 1'b1) begin
                waited = c;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (dport) begin d_req = 0; d_wen = 0; end
        else begin i_req = 0; i_wen = 0; end
    endtask

    task automatic ack_port(input bit dport);
        if (dport) d_ack = 1; else i_ack = 1;
        @(posedge clk);
        #1;
        d_ack = 0; i_ack = 0;
    endtask

    task automatic test_reset();
        logic [82:0] obs;
        idle_inputs();
        resetn = 1'b0;
        #12;
        obs = {i_gnt0, d_gnt0, i_recv0, d_recv0, i_err0, d_err0, cen0, ra0, i_rd0, d_rd0};
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        obs = {i_gnt0, d_gnt0, i_recv0, d_recv0, i_err0, d_err0, cen0, ra0, i_rd0, d_rd0};
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h expected 0", obs);
        end
        n_checks++;
        if ({wd0, ws0} !== 36'h0) begin
            n_fail++;
            $display("FAIL rom_write_tie: got %h expected 0", {wd0, ws0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        int w;
        issue(1'b0, 12'h004, 1'b0, w);
        n_checks++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL read_gnt_latency: got %0d expected 0", w);
        end
        @(negedge clk);
        n_checks++;
        if ({i_recv0, i_err0, i_rd0, d_recv0} !== {1'b1, 1'b0, 32'h11223344, 1'b0}) begin
            n_fail++;
            $display("FAIL read_word1: recv=%b err=%b rdata=%h drecv=%b expected 1 0 11223344 0",
                     i_recv0, i_err0, i_rd0, d_recv0);
        end
        ack_port(1'b0);
        @(negedge clk);
        n_checks++;
        if (i_recv0 !== 1'b0) begin
            n_fail++;
            $display("FAIL recv_after_ack: got %b expected 0", i_recv0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_arbitration();
        int got0[3] = '{-1, -1, -1};
        int got1[3] = '{-1, -1, -1};
        int exp_rr[3], exp_fp[3];
        int n0 = 0, n1 = 0, overlap = 0, last_rr = 1, last_fp = 1;
        for (int k = 0; k < 3; k++) begin
            exp_rr[k] = (last_rr == 1) ? 0 : 1;
            last_rr   = exp_rr[k];
            exp_fp[k] = 0;
            last_fp   = exp_fp[k];
        end
        do_reset();
        i_req = 1; i_addr = 12'h010; d_req = 1; d_addr = 12'h020;
        i_ack = 1; d_ack = 1;
        for (int c = 0; c < 12 && (n0 < 3 || n1 < 3); c++) begin
            @(negedge clk);
            if (i_gnt0 === 1'b1 && d_gnt0 === 1'b1) overlap++;
            if (i_gnt1 === 1'b1 && d_gnt1 === 1'b1) overlap++;
            if (n0 < 3 && i_gnt0 === 1'b1) begin got0[n0] = 0; n0++; end
            else if (n0 < 3 && d_gnt0 === 1'b1) begin got0[n0] = 1; n0++; end
            if (n1 < 3 && i_gnt1 === 1'b1) begin got1[n1] = 0; n1++; end
            else if (n1 < 3 && d_gnt1 === 1'b1) begin got1[n1] = 1; n1++; end
        end
        @(posedge clk);
        #1 i_req = 0; d_req = 0;
        @(posedge clk);
        #1 i_ack = 0; d_ack = 0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (got0[k] !== exp_rr[k]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", k, got0[k], exp_rr[k]);
            end
            n_checks++;
            if (got1[k] !== exp_fp[k]) begin
                n_fail++;
                $display("FAIL fixed_order[%0d]: got %0d expected %0d", k, got1[k], exp_fp[k]);
            end
        end
        n_checks++;
        if (overlap !== 0) begin
            n_fail++;
            $display("FAIL gnt_onehot: got %0d overlaps expected 0", overlap);
        end
    endtask

    task automatic test_errors();
        bit          dp[3] = '{1'b1, 1'b0, 1'b0};
        logic [11:0] ad[3] = '{12'h008, 12'h002, 12'h100};
        bit          wn[3] = '{1'b1, 1'b0, 1'b0};
        int          w, c0;
        for (int k = 0; k < 3; k++) begin
            c0 = cen_cnt0;
            issue(dp[k], ad[k], wn[k], w);
            @(negedge clk);
            n_checks++;
            if ((dp[k] ? {d_recv0, d_err0, d_rd0} : {i_recv0, i_err0, i_rd0}) !== {1'b1, 1'b1, 32'h0}
                || w !== 0) begin
                n_fail++;
                $display("FAIL error_resp[%0d]: recv/err/rdata=%h wait=%0d expected 1/1/0 wait 0", k,
                         dp[k] ? {d_recv0, d_err0, d_rd0} : {i_recv0, i_err0, i_rd0}, w);
            end
            n_checks++;
            if (cen_cnt0 !== c0) begin
                n_fail++;
                $display("FAIL error_no_cen[%0d]: got %0d cen pulses expected 0", k, cen_cnt0 - c0);
            end
            ack_port(dp[k]);
        end
    endtask

    task automatic test_hold_ack();
        int w;
        issue(1'b0, 12'h000, 1'b0, w);
        d_req = 1; d_addr = 12'h040; d_wen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({i_recv0, i_rd0, i_gnt0, d_gnt0} !== {1'b1, rom_word(0), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_ack[%0d]: recv=%b rdata=%h ignt=%b dgnt=%b expected 1 %h 0 0",
                         c, i_recv0, i_rd0, i_gnt0, d_gnt0, rom_word(0));
            end
            @(posedge clk);
            #1;
        end
        ack_port(1'b0);
        @(negedge clk);
        n_checks++;
        if (d_gnt0 !== 1'b1) begin
            n_fail++;
            $display("FAIL dmem_gnt_after_ack: got %b expected 1", d_gnt0);
        end
        @(posedge clk);
        #1 d_req = 0;
        @(negedge clk);
        n_checks++;
        if ({d_recv0, d_rd0} !== {1'b1, rom_word(16)}) begin
            n_fail++;
            $display("FAIL dmem_read_040: got %h expected %h", {d_recv0, d_rd0}, {1'b1, rom_word(16)});
        end
        ack_port(1'b1);
    endtask

    task automatic test_reset_in_resp();
        int w;
        issue(1'b0, 12'h008, 1'b0, w);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({i_recv0, i_rd0} !== 33'h0) begin
            n_fail++;
            $display("FAIL recv_drop_on_reset: got %h expected 0", {i_recv0, i_rd0});
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        issue(1'b0, 12'h0FC, 1'b0, w);
        @(negedge clk);
        n_checks++;
        if ({i_recv0, i_err0, i_rd0} !== {1'b1, 1'b0, rom_word(63)} || w !== 0) begin
            n_fail++;
            $display("FAIL read_last_word: got %h wait=%0d expected %h wait 0",
                     {i_recv0, i_err0, i_rd0}, w, {1'b1, 1'b0, rom_word(63)});
        end
        ack_port(1'b0);
    endtask

    function automatic logic [11:0] rand_addr();
        if ($urandom_range(0, 3) != 0) return {4'h0, 6'($urandom_range(0, 63)), 2'b00};
        return 12'($urandom);
    endfunction

    task automatic test_random();
        bit          busy = 0, own = 0, merr = 0, last = 1, g_i = 0, g_d = 0;
        bit          eig, edg, ebad;
        logic [31:0] mrd = '0;
        logic [11:0] a;
        logic [82:0] obs, expv;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (g_i) i_req = 0;
            else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = rand_addr(); i_wen = ($urandom_range(0, 7) == 0);
            end else if (i_req && $urandom_range(0, 15) == 0) i_req = 0;
            if (g_d) d_req = 0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_addr = rand_addr(); d_wen = ($urandom_range(0, 7) == 0);
            end else if (d_req && $urandom_range(0, 15) == 0) d_req = 0;
            i_ack = 1'($urandom_range(0, 1));
            d_ack = 1'($urandom_range(0, 1));
            g_i = 0; g_d = 0;
            @(negedge clk);
            eig = 0; edg = 0; ebad = 0; a = '0;
            if (!busy) begin
                eig  = i_req && (!d_req || last == 1);
                edg  = d_req && !eig;
                a    = edg ? d_addr : i_addr;
                ebad = (edg ? d_wen : i_wen) || (a % 4 != 0) || (int'(a) >= 256);
                expv = {eig, edg, 4'b0000, (eig || edg) && !ebad,
                        ((eig || edg) && !ebad) ? a : 12'h0, 64'h0};
            end else begin
                expv = {2'b00, !own, own, !own && merr, own && merr, 1'b0, 12'h0,
                        own ? 32'h0 : mrd, own ? mrd : 32'h0};
            end
            obs = {i_gnt0, d_gnt0, i_recv0, d_recv0, i_err0, d_err0, cen0, ra0, i_rd0, d_rd0};
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random_cycle[%0d]: got %h expected %h", cyc, obs, expv);
            end
            if (!busy && (eig || edg)) begin
                busy = 1; own = edg; merr = ebad; last = edg;
                mrd  = ebad ? 32'h0 : rom_word(int'(a) / 4);
                g_i  = eig; g_d = edg;
            end else if (busy && (own ? d_ack : i_ack)) begin
                busy = 0;
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        i_ack = 1; d_ack = 1;
        @(posedge clk);
        #1 idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_arbitration();
        test_errors();
        test_hold_ack();
        test_reset_in_resp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
